// File: rtl/sobel_pkg.sv
// Shared types and helpers for the sobel work-item dispatcher slice.
package sobel_pkg;

  localparam int ID_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic hs_fire(input logic valid, input logic stall);
    return valid & ~stall;
  endfunction

endpackage

// File: rtl/sobel_inflight_counter.sv
// Issued/retired bookkeeping for the dispatcher: in-flight count, throttle compare, sticky error.
module sobel_inflight_counter #(
  parameter int          ID_W         = 32,
  parameter int unsigned MAX_INFLIGHT = 64
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            clear_i,
  input  logic            fire_i,
  input  logic            valid_i,
  output logic [ID_W-1:0] issued_o,
  output logic [ID_W-1:0] retired_next_o,
  output logic [ID_W-1:0] inflight_o,
  output logic            below_max_o,
  output logic            err_o
);

  localparam logic [ID_W-1:0] MaxC = ID_W'(MAX_INFLIGHT);

  logic [ID_W-1:0] issued_q, issued_d;
  logic [ID_W-1:0] retired_q, retired_d;
  logic [ID_W-1:0] inflight;
  logic            err_q, err_d;
  logic            retire;

  // A retirement with nothing outstanding is flagged and otherwise dropped.
  always_comb begin
    inflight  = issued_q - retired_q;
    retire    = valid_i & (inflight != '0);
    issued_d  = issued_q + ID_W'(fire_i);
    retired_d = retired_q + ID_W'(retire);
    err_d     = err_q | (valid_i & (inflight == '0));
    if (clear_i) begin
      issued_d  = '0;
      retired_d = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      issued_q  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      issued_q  <= issued_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign issued_o       = issued_q;
  assign retired_next_o = retired_d;
  assign inflight_o     = inflight;
  assign below_max_o    = inflight < MaxC;
  assign err_o          = err_q;

endmodule

// File: rtl/sobel_workitem_dispatcher.sv
// Issues workgroup items into the first sobel block, retires them from the last, pulses done.
module sobel_workitem_dispatcher
  import sobel_pkg::*;
#(
  parameter int          ID_W         = ID_W_DEFAULT,
  parameter int unsigned MAX_INFLIGHT = 64
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [ID_W-1:0] workgroup_size,
  output logic            valid_out,
  input  logic            stall_in,
  output logic [ID_W-1:0] global_id,
  output logic            last,
  input  logic            valid_in,
  output logic            stall_out,
  output logic            busy,
  output logic            done,
  output logic [ID_W-1:0] inflight,
  output logic            err
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] size_q, size_d;
  logic [ID_W-1:0] issued, retiredNext;
  logic            clear, fire, belowMax;

  sobel_inflight_counter #(
    .ID_W         (ID_W),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_counter (
    .clock          (clock),
    .resetn         (resetn),
    .clear_i        (clear),
    .fire_i         (fire),
    .valid_i        (valid_in),
    .issued_o       (issued),
    .retired_next_o (retiredNext),
    .inflight_o     (inflight),
    .below_max_o    (belowMax),
    .err_o          (err)
  );

  // valid_out is built from registered state only, so stall_in/valid_in never reach it.
  assign valid_out = (state_q == ISSUE) & belowMax;
  assign fire      = hs_fire(valid_out, stall_in);
  assign global_id = issued;
  assign last      = (issued == (size_q - ID_W'(1)));
  assign stall_out = 1'b0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          size_d  = workgroup_size;
          clear   = 1'b1;
          state_d = (workgroup_size != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (fire && last) state_d = DRAIN;
      end
      DRAIN: begin
        // Look at the post-retire count so the final retire completes in the same cycle.
        if (retiredNext == size_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_sobel_workitem_dispatcher.sv
// Directed scoreboard bench for sobel_workitem_dispatcher (default instance plus a MAX_INFLIGHT=2 instance).
module tb_sobel_workitem_dispatcher;

  typedef struct {
    int unsigned id;
    logic        last;
  } item_t;

  typedef struct {
    int   cyc;
    logic isLast;
  } ret_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start, stall_in, valid_in;
  logic [31:0] workgroup_size;
  logic        valid_out, last, stall_out, busy, done, err;
  logic [31:0] global_id, inflight;

  logic        tStart, tStall, tValidIn;
  logic [31:0] tSize;
  logic        tValidOut, tLast, tStallOut, tBusy, tDone, tErr;
  logic [31:0] tGlobalId, tInflight;

  item_t expQ[$];
  item_t expQT[$];
  ret_t  retQ[$];
  int    doneQ[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fires = 0;
  int tFires = 0;
  int doneCount = 0;
  int tDoneCount = 0;
  int lastDoneCyc = -10;
  int validSeen = 0;
  bit autoRetire = 1'b0;
  int snap;

  always #5 clock = ~clock;

  sobel_workitem_dispatcher dut (
    .clock          (clock),
    .resetn         (resetn),
    .start          (start),
    .workgroup_size (workgroup_size),
    .valid_out      (valid_out),
    .stall_in       (stall_in),
    .global_id      (global_id),
    .last           (last),
    .valid_in       (valid_in),
    .stall_out      (stall_out),
    .busy           (busy),
    .done           (done),
    .inflight       (inflight),
    .err            (err)
  );

  sobel_workitem_dispatcher #(.ID_W(32), .MAX_INFLIGHT(2)) dutT (
    .clock          (clock),
    .resetn         (resetn),
    .start          (tStart),
    .workgroup_size (tSize),
    .valid_out      (tValidOut),
    .stall_in       (tStall),
    .global_id      (tGlobalId),
    .last           (tLast),
    .valid_in       (tValidIn),
    .stall_out      (tStallOut),
    .busy           (tBusy),
    .done           (tDone),
    .inflight       (tInflight),
    .err            (tErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive scheduled retires, score fires/done on both instances, then advance.
  task automatic cycle();
    item_t e;
    ret_t  r;
    int    dExp;
    if (autoRetire) begin
      valid_in = 1'b0;
      if (retQ.size() > 0 && retQ[0].cyc == cyc) begin
        r = retQ.pop_front();
        valid_in = 1'b1;
        if (r.isLast) doneQ.push_back(cyc + 1);
      end
    end
    #1;
    if (valid_out) validSeen++;
    if (valid_out && !stall_in) begin
      fires++;
      if (expQ.size() > 0) e = expQ.pop_front();
      else e = '{32'hDEAD_BEEF, 1'b0};
      check("fire_id", global_id, e.id);
      check("fire_last", {31'b0, last}, {31'b0, e.last});
      if (autoRetire) retQ.push_back('{cyc + 3, e.last});
    end
    if (done) begin
      doneCount++;
      lastDoneCyc = cyc;
      dExp = (doneQ.size() > 0) ? doneQ[0] : -1;
      if (doneQ.size() > 0) void'(doneQ.pop_front());
      check("done_cycle", cyc, dExp);
    end
    if (tValidOut && !tStall) begin
      tFires++;
      if (expQT.size() > 0) e = expQT.pop_front();
      else e = '{32'hDEAD_BEEF, 1'b0};
      check("t_fire_id", tGlobalId, e.id);
      check("t_fire_last", {31'b0, tLast}, {31'b0, e.last});
    end
    if (tDone) tDoneCount++;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input int unsigned size);
    start = 1'b1;
    workgroup_size = size;
    for (int i = 0; i < int'(size); i++) expQ.push_back('{i, (i == int'(size) - 1)});
    if (size == 0) doneQ.push_back(cyc + 1);
    cycle();
    start = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      cycle();
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_busy_fall"}, cyc, lastDoneCyc + 1);
    check({tag, "_done_pending"}, doneQ.size(), 32'd0);
    check({tag, "_ids_left"}, expQ.size(), 32'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0; stall_in = 1'b0; valid_in = 1'b0; workgroup_size = '0;
    tStart = 1'b0; tStall = 1'b0; tValidIn = 1'b0; tSize = '0;
    #1;
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);
    check("rst_global_id", global_id, 32'd0);
    check("rst_last", {31'b0, last}, 32'd0);
    check("rst_stall_out", {31'b0, stall_out}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_inflight", inflight, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Plain workgroup of 4, retires 3 cycles after issue.
    autoRetire = 1'b1;
    snap = fires;
    applyStimulus(4);
    check("t1_valid_latency", {31'b0, valid_out}, 32'd1);
    check("t1_first_id", global_id, 32'd0);
    snap = doneCount;
    checkOutput("t1");
    check("t1_fires", fires, 32'd4 + 32'(snap - snap));
    check("t1_done_once", doneCount - snap, 32'd1);

    // Stall while id 1 is presented.
    snap = fires;
    applyStimulus(3);
    cycle();
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'b0, valid_out}, 32'd1);
      check("t2_hold_id", global_id, 32'd1);
      check("t2_hold_last", {31'b0, last}, 32'd0);
      cycle();
    end
    stall_in = 1'b0;
    checkOutput("t2");
    check("t2_fires", fires - snap, 32'd3);

    // Throttle on the MAX_INFLIGHT=2 instance.
    tStart = 1'b1;
    tSize = 5;
    for (int i = 0; i < 5; i++) expQT.push_back('{i, (i == 4)});
    cycle();
    tStart = 1'b0;
    cycle();
    cycle();
    check("t3_throttled", {31'b0, tValidOut}, 32'd0);
    check("t3_inflight", tInflight, 32'd2);
    cycle();
    check("t3_still_throttled", {31'b0, tValidOut}, 32'd0);
    check("t3_next_id", tGlobalId, 32'd2);
    tValidIn = 1'b1;
    cycle();
    tValidIn = 1'b0;
    check("t3_reassert", {31'b0, tValidOut}, 32'd1);
    check("t3_reassert_id", tGlobalId, 32'd2);
    check("t3_inflight_after", tInflight, 32'd1);
    for (int n = 0; n < 60 && tBusy; n++) begin
      tValidIn = (tInflight != 0);
      cycle();
    end
    tValidIn = 1'b0;
    check("t3_idle", {31'b0, tBusy}, 32'd0);
    check("t3_fires", tFires, 32'd5);
    check("t3_done", tDoneCount, 32'd1);
    check("t3_err", {31'b0, tErr}, 32'd0);
    check("t3_stall_out", {31'b0, tStallOut}, 32'd0);

    // Empty workgroup.
    validSeen = 0;
    applyStimulus(0);
    check("t4_busy", {31'b0, busy}, 32'd1);
    check("t4_done", {31'b0, done}, 32'd1);
    cycle();
    check("t4_idle", {31'b0, busy}, 32'd0);
    check("t4_no_valid", validSeen, 32'd0);
    check("t4_done_pending", doneQ.size(), 32'd0);

    // Stray retire in IDLE, then an ignored second start.
    autoRetire = 1'b0;
    valid_in = 1'b1;
    cycle();
    valid_in = 1'b0;
    check("t5_err_set", {31'b0, err}, 32'd1);
    check("t5_inflight", inflight, 32'd0);
    cycle();
    check("t5_err_sticky", {31'b0, err}, 32'd1);
    autoRetire = 1'b1;
    snap = fires;
    applyStimulus(4);
    cycle();
    start = 1'b1;
    workgroup_size = 9;
    cycle();
    start = 1'b0;
    checkOutput("t5");
    check("t5_fires", fires - snap, 32'd4);
    check("t5_err_still", {31'b0, err}, 32'd1);

    // Reset during DRAIN.
    autoRetire = 1'b0;
    applyStimulus(3);
    cycle();
    cycle();
    cycle();
    check("t6_busy", {31'b0, busy}, 32'd1);
    check("t6_inflight", inflight, 32'd3);
    check("t6_valid_drain", {31'b0, valid_out}, 32'd0);
    snap = doneCount;
    resetn = 1'b0;
    #1;
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    check("t6_rst_inflight", inflight, 32'd0);
    check("t6_rst_err", {31'b0, err}, 32'd0);
    check("t6_rst_id", global_id, 32'd0);
    check("t6_rst_last", {31'b0, last}, 32'd0);
    check("t6_rst_done", {31'b0, done}, 32'd0);
    check("t6_rst_valid", {31'b0, valid_out}, 32'd0);
    @(posedge clock);
    #1;
    cyc++;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("t6_no_done", doneCount - snap, 32'd0);
    autoRetire = 1'b1;
    applyStimulus(2);
    checkOutput("t6");
    check("t6_done_after", doneCount - snap, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sobel_workitem_dispatcher.md
Name: sobel_workitem_dispatcher

Overview:
- Drives work-items into the first sobel basic block and retires them from the last block's exit.
- Issue side is the transmitter end of the valid/stall handshake: it asserts valid_out and honours stall_in. Completion side is the receiver end: it accepts valid_in and drives stall_out.
- Throttles in-flight items and pulses done once every issued item of the workgroup has retired.

Parameters:
- ID_W, 32, width of workgroup_size, global_id and internal counters.
- MAX_INFLIGHT, 64, maximum issued-but-not-retired items; range 1..2^ID_W-1.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle launch request; sampled only in IDLE.
- workgroup_size  in  ID_W  item count; latched on accepted start.
- valid_out  out  1  work-item valid toward first block.
- stall_in  in  1  first block stall; an item transfers when valid_out & ~stall_in.
- global_id  out  ID_W  id of the presented item (0..size-1).
- last  out  1  presented item is the final one of the workgroup.
- valid_in  in  1  retirement valid from last block exit.
- stall_out  out  1  stall to last block; constant 0 (always accepts).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the workgroup is complete.
- inflight  out  ID_W  issued minus retired count.
- err  out  1  sticky: retirement arrived with inflight==0.

Behaviour:
- Reset values: valid_out=0, global_id=0, last=0, stall_out=0, busy=0, done=0, inflight=0, err=0, state=IDLE. Reset mid-operation aborts the workgroup with no done pulse.
- Registers: size_q, issued, retired, err, state. All ID_W wide, unsigned, modulo 2^ID_W.
- Derived signals:
  - inflight = issued - retired.
  - global_id = issued.
  - last = (issued == size_q-1).
  - valid_out = (state==ISSUE) & (inflight < MAX_INFLIGHT).
- No combinational path from stall_in or valid_in to valid_out. valid_out depends on registers only.
- Transfers:
  - fire = valid_out & ~stall_in.
  - retire = valid_in & (inflight != 0).
  - valid_in with inflight==0 sets err and is otherwise ignored. err clears only on reset.
- State machine:
  - IDLE: on start, latch size_q=workgroup_size, clear issued and retired. Go to ISSUE if size != 0, else DONE.
  - ISSUE: fire increments issued. Fire with last=1 goes to DRAIN.
  - DRAIN: when retired == size_q (including a retire this cycle reaching it), go to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE.
- Latency:
  - Start accepted in cycle t gives valid_out=1 in t+1 (if size>0).
  - Final retire in cycle t gives done=1 in t+1.
  - size==0: done in t+1.
- Holding: while valid_out=1 and stall_in=1, global_id and last hold stable.
- Throttle: valid_out drops when inflight reaches MAX_INFLIGHT. It reasserts the cycle after any retire lowers inflight.
- Simultaneous fire and retire in one cycle: inflight unchanged, issued+1, retired+1.
- Retirements are accepted in every state, so late retires during ISSUE are normal.
- start outside IDLE is ignored; workgroup_size changes outside IDLE are ignored.

Decomposition:
- Shared package sobel_pkg:
  - state enum IDLE/ISSUE/DRAIN/DONE (2-bit);
  - ID_W default constant;
  - handshake fire helper function (valid & ~stall).
- One natural sub-module, sobel_inflight_counter. It holds the issued/retired counters and provides inflight, the less-than-MAX compare and err.
- FSM stays in the top level.

Test Plan:
- size=4, stall_in=0, each item retired 3 cycles after issue -> global_id 0,1,2,3 on consecutive cycles; last=1 only with id 3; done pulses once, 1 cycle after 4th retire; busy falls with it.
- size=3, stall_in=1 for 5 cycles while id=1 is presented -> valid_out stays 1, global_id holds 1 and last holds 0 throughout; exactly 3 fires total.
- MAX_INFLIGHT=2, size=5, no retires -> valid_out deasserts after id 1 with inflight=2. One retire -> valid_out reasserts next cycle with id 2.
- size=0 start -> busy=1 for 1 cycle, done pulse at t+1, valid_out never asserted.
- valid_in pulse while IDLE -> err=1 sticky, inflight stays 0. Second start mid-ISSUE with size=9 -> ignored, original size completes.
- resetn low during DRAIN with inflight=3 -> all outputs at reset values asynchronously, no done. Subsequent start with size=2 completes normally.
